// File: rtl/im_prog.sv
// Instruction memory with a runtime program-load port and a 1-cycle registered fetch port.
// The loader FSM owns the array while prog_en is high; fetches are stalled until RUN.
module im_prog #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 64,
    parameter int                PC_W       = 32,
    parameter bit                BYTE_ADDR  = 1'b1,
    parameter logic [DATA_W-1:0] FAULT_INST = '0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       prog_en,
    input  logic                       prog_start,
    input  logic [$clog2(DEPTH)-1:0]   prog_base,
    input  logic                       prog_we,
    input  logic [DATA_W-1:0]          prog_data,
    output logic                       prog_wrap,
    output logic [$clog2(DEPTH):0]     load_count,
    input  logic                       fetch_req,
    input  logic [PC_W-1:0]            pc,
    output logic                       fetch_ready,
    output logic [DATA_W-1:0]          inst,
    output logic                       inst_valid,
    output logic                       fault
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW-1:0]  LAST_IX = AW'(DEPTH - 1);
    localparam logic [AW:0]    CNT_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_load_entry;
    logic                w_in_load;
    logic                w_accept;

    logic [AW-1:0]       r_ptr;
    logic                r_wrap;
    logic [AW:0]         r_count;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [AW-1:0]       w_waddr;
    logic                w_we;
    logic [PC_W-1:0]     w_index;
    logic                w_misalign;
    logic                w_oor;
    logic                w_fault_c;

    logic [DATA_W-1:0]   r_inst_p1;
    logic                r_vld_p1;
    logic                r_fault_p1;

    // FSM: state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= ST_EMPTY;
        else        r_state <= w_next_state;
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (prog_en)  w_next_state = ST_LOAD;
            ST_LOAD:  if (!prog_en) w_next_state = ST_RUN;
            ST_RUN:   if (prog_en)  w_next_state = ST_LOAD;
            default:                w_next_state = ST_EMPTY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        fetch_ready  = 1'b0;
        w_in_load    = 1'b0;
        w_load_entry = 1'b0;
        case (r_state)
            ST_RUN:  begin
                fetch_ready  = 1'b1;
                w_load_entry = prog_en;
            end
            ST_LOAD: w_in_load = 1'b1;
            default: w_load_entry = prog_en;
        endcase
    end

    // A prog_start in the same cycle as prog_we writes at prog_base directly.
    assign w_waddr = prog_start ? prog_base : r_ptr;
    assign w_we    = w_in_load && prog_we;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_ptr   <= '0;
            r_wrap  <= 1'b0;
            r_count <= '0;
        end else if (w_load_entry) begin
            r_wrap  <= 1'b0;
            r_count <= '0;
        end else if (w_in_load && (prog_start || prog_we)) begin
            r_ptr <= prog_we ? (w_waddr + AW'(1)) : w_waddr;
            if (w_we && (w_waddr == LAST_IX)) r_wrap <= 1'b1;
            if (w_we && (r_count != CNT_MAX)) r_count <= r_count + (AW + 1)'(1);
        end
    end

    // Array has no reset so a program survives a mid-load reset.
    always_ff @(posedge Clk) begin
        if (w_we) r_mem[w_waddr] <= prog_data;
    end

    assign w_accept   = fetch_ready && fetch_req;
    assign w_index    = BYTE_ADDR ? (pc >> 2) : pc;
    assign w_misalign = BYTE_ADDR && (pc[1:0] != 2'b00);
    assign w_oor      = |(w_index >> AW);
    assign w_fault_c  = w_misalign || w_oor;

    // Fetch stage p0 -> p1: registered read, one result per accepted request
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_inst_p1  <= '0;
            r_vld_p1   <= 1'b0;
            r_fault_p1 <= 1'b0;
        end else begin
            r_vld_p1   <= w_accept;
            r_fault_p1 <= w_accept && w_fault_c;
            if (w_accept) r_inst_p1 <= w_fault_c ? FAULT_INST : r_mem[w_index[AW-1:0]];
        end
    end

    assign inst       = r_inst_p1;
    assign inst_valid = r_vld_p1;
    assign fault      = r_fault_p1;
    assign prog_wrap  = r_wrap;
    assign load_count = r_count;

endmodule

// File: tb/tb_im_prog.sv
// Directed bench for im_prog: byte-addressed instance plus a word-indexed instance.
module tb_im_prog;

    localparam int          DW    = 32;
    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [31:0] FI    = 32'h0000_0013;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;

    logic          prog_en = 0, prog_start = 0, prog_we = 0, fetch_req = 0;
    logic [AW-1:0] prog_base = '0;
    logic [DW-1:0] prog_data = '0;
    logic [31:0]   pc = '0;
    logic          prog_wrap, fetch_ready, inst_valid, fault;
    logic [AW:0]   load_count;
    logic [DW-1:0] inst;

    logic          w_prog_en = 0, w_prog_start = 0, w_prog_we = 0, w_fetch_req = 0;
    logic [AW-1:0] w_prog_base = '0;
    logic [DW-1:0] w_prog_data = '0;
    logic [31:0]   w_pc = '0;
    logic          w_prog_wrap, w_fetch_ready, w_inst_valid, w_fault;
    logic [AW:0]   w_load_count;
    logic [DW-1:0] w_inst;

    int n_checks = 0;
    int n_fail   = 0;

    im_prog #(.DATA_W(DW), .DEPTH(DEPTH), .PC_W(32), .BYTE_ADDR(1'b1), .FAULT_INST(FI)) u_dut (
        .Clk(Clk), .Reset(Reset), .prog_en(prog_en), .prog_start(prog_start),
        .prog_base(prog_base), .prog_we(prog_we), .prog_data(prog_data),
        .prog_wrap(prog_wrap), .load_count(load_count), .fetch_req(fetch_req), .pc(pc),
        .fetch_ready(fetch_ready), .inst(inst), .inst_valid(inst_valid), .fault(fault)
    );

    im_prog #(.DATA_W(DW), .DEPTH(DEPTH), .PC_W(32), .BYTE_ADDR(1'b0), .FAULT_INST(FI)) u_dut_w (
        .Clk(Clk), .Reset(Reset), .prog_en(w_prog_en), .prog_start(w_prog_start),
        .prog_base(w_prog_base), .prog_we(w_prog_we), .prog_data(w_prog_data),
        .prog_wrap(w_prog_wrap), .load_count(w_load_count), .fetch_req(w_fetch_req), .pc(w_pc),
        .fetch_ready(w_fetch_ready), .inst(w_inst), .inst_valid(w_inst_valid), .fault(w_fault)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        // Intentionally unused: each test compares inline.
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", fetch_ready); end
        n_checks++; if (load_count !== 7'd0 || prog_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_load: count %0d wrap %b want 0 0", load_count, prog_wrap); end
        Reset = 1'b1;
    endtask

    task automatic test_load_fetch();
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        prog_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            prog_start = (i == 0); prog_base = '0; prog_we = 1'b1; prog_data = words[i];
            tick();
        end
        prog_start = 0; prog_we = 0; prog_en = 0;
        tick();
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready: got %b want 1", fetch_ready); end
        n_checks++; if (load_count !== 7'd3) begin n_fail++; $display("FAIL t1_count: got %0d want 3", load_count); end
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i * 4);
            tick();
            n_checks++;
            if (inst !== words[i] || inst_valid !== 1'b1 || fault !== 1'b0) begin
                n_fail++; $display("FAIL t1_fetch%0d: got inst %h vld %b flt %b want %h 1 0", i, inst, inst_valid, fault, words[i]);
            end
        end
        fetch_req = 1'b0;
        tick();
        n_checks++; if (inst_valid !== 1'b0 || inst !== 32'h33) begin n_fail++; $display("FAIL t1_idle: got vld %b inst %h want 0 33", inst_valid, inst); end
    endtask

    task automatic test_fault();
        fetch_req = 1'b1; pc = 32'h6;
        tick();
        n_checks++; if (fault !== 1'b1 || inst !== FI || inst_valid !== 1'b1) begin n_fail++; $display("FAIL t2_misalign: got flt %b inst %h vld %b want 1 %h 1", fault, inst, inst_valid, FI); end
        pc = 32'(DEPTH * 4);
        tick();
        n_checks++; if (fault !== 1'b1 || inst !== FI) begin n_fail++; $display("FAIL t2_range: got flt %b inst %h want 1 %h", fault, inst, FI); end
        pc = 32'h8;
        tick();
        n_checks++; if (fault !== 1'b0 || inst !== 32'h33) begin n_fail++; $display("FAIL t2_recover: got flt %b inst %h want 0 33", fault, inst); end
        fetch_req = 1'b0;
    endtask

    task automatic test_wrap();
        prog_en = 1'b1;
        tick();
        n_checks++; if (prog_wrap !== 1'b0 || load_count !== 7'd0) begin n_fail++; $display("FAIL t3_entry: got wrap %b count %0d want 0 0", prog_wrap, load_count); end
        prog_start = 1'b1; prog_base = AW'(DEPTH - 1); prog_we = 1'b1; prog_data = 32'hAA;
        tick();
        prog_start = 1'b0; prog_data = 32'hBB;
        tick();
        prog_we = 1'b0; prog_en = 1'b0;
        tick();
        n_checks++; if (prog_wrap !== 1'b1 || load_count !== 7'd2) begin n_fail++; $display("FAIL t3_wrap: got wrap %b count %0d want 1 2", prog_wrap, load_count); end
        fetch_req = 1'b1; pc = 32'((DEPTH - 1) * 4);
        tick();
        n_checks++; if (inst !== 32'hAA || fault !== 1'b0) begin n_fail++; $display("FAIL t3_last: got inst %h flt %b want aa 0", inst, fault); end
        pc = 32'h0;
        tick();
        n_checks++; if (inst !== 32'hBB || fault !== 1'b0) begin n_fail++; $display("FAIL t3_first: got inst %h flt %b want bb 0", inst, fault); end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        fetch_req = 1'b1; pc = 32'h4;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) prog_en = 1'b1;
            tick();
            n_checks++;
            if (fetch_ready !== 1'b0 || inst_valid !== 1'b0) begin
                n_fail++; $display("FAIL t4_stall%0d: got rdy %b vld %b want 0 0", i, fetch_ready, inst_valid);
            end
        end
        prog_en = 1'b0;
        tick();
        n_checks++; if (fetch_ready !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL t4_run_entry: got rdy %b vld %b want 1 0", fetch_ready, inst_valid); end
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h22) begin n_fail++; $display("FAIL t4_retained: got vld %b inst %h want 1 22", inst_valid, inst); end
    endtask

    task automatic test_run_to_load();
        fetch_req = 1'b1; pc = 32'h8; prog_en = 1'b1;
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h33 || fetch_ready !== 1'b0) begin n_fail++; $display("FAIL t_r2l_last: got vld %b inst %h rdy %b want 1 33 0", inst_valid, inst, fetch_ready); end
        tick();
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL t_r2l_drop: got vld %b want 0", inst_valid); end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset_midload();
        prog_start = 1'b1; prog_base = '0; prog_we = 1'b1; prog_data = 32'h55;
        tick();
        prog_start = 1'b0; prog_data = 32'h66;
        tick();
        n_checks++; if (load_count !== 7'd2) begin n_fail++; $display("FAIL t5_partial: got count %0d want 2", load_count); end
        prog_data = 32'h77;
        Reset = 1'b0;
        #1;
        n_checks++; if (load_count !== 7'd0 || fetch_ready !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL t5_async: got count %0d rdy %b vld %b want 0 0 0", load_count, fetch_ready, inst_valid); end
        tick();
        prog_we = 1'b0; prog_en = 1'b0;
        Reset = 1'b1;
        prog_en = 1'b1;
        tick();
        prog_en = 1'b0;
        tick();
        n_checks++; if (fetch_ready !== 1'b1 || load_count !== 7'd0) begin n_fail++; $display("FAIL t5_run: got rdy %b count %0d want 1 0", fetch_ready, load_count); end
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp;
            exp = (i == 0) ? 32'h55 : (i == 1) ? 32'h66 : 32'h33;
            pc = 32'(i * 4);
            tick();
            n_checks++;
            if (inst !== exp || inst_valid !== 1'b1) begin
                n_fail++; $display("FAIL t5_fetch%0d: got inst %h vld %b want %h 1", i, inst, inst_valid, exp);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_word_addr();
        w_prog_en = 1'b1;
        tick();
        w_prog_start = 1'b1; w_prog_base = AW'(5); w_prog_we = 1'b1; w_prog_data = 32'hC5;
        tick();
        w_prog_start = 1'b0; w_prog_data = 32'hC6;
        tick();
        w_prog_we = 1'b0; w_prog_en = 1'b0;
        tick();
        w_fetch_req = 1'b1; w_pc = 32'd5;
        tick();
        n_checks++; if (w_inst !== 32'hC5 || w_fault !== 1'b0 || w_inst_valid !== 1'b1) begin n_fail++; $display("FAIL t6_pc5: got inst %h flt %b vld %b want c5 0 1", w_inst, w_fault, w_inst_valid); end
        w_pc = 32'd6;
        tick();
        n_checks++; if (w_inst !== 32'hC6 || w_fault !== 1'b0) begin n_fail++; $display("FAIL t6_pc6: got inst %h flt %b want c6 0", w_inst, w_fault); end
        w_pc = 32'(DEPTH);
        tick();
        n_checks++; if (w_fault !== 1'b1 || w_inst !== FI) begin n_fail++; $display("FAIL t6_range: got flt %b inst %h want 1 %h", w_fault, w_inst, FI); end
        w_pc = 32'(DEPTH - 1);
        tick();
        n_checks++; if (w_fault !== 1'b0 || w_inst_valid !== 1'b1) begin n_fail++; $display("FAIL t6_edge: got flt %b vld %b want 0 1", w_fault, w_inst_valid); end
        w_fetch_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_fault();
        test_wrap();
        test_stall();
        test_run_to_load();
        test_reset_midload();
        test_word_addr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
